// File: rtl/uart_tx_datapath_if.sv
// Handshake between the UART TX controller (master) and the TX data path (slave).
interface uart_tx_datapath_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  LOAD_EN;
  logic                  TRANSMIT_EN;
  logic [DATA_WIDTH-1:0] DATA_IN;
  logic                  DONE;
  logic                  TX;

  modport master (output LOAD_EN, output TRANSMIT_EN, output DATA_IN, input DONE, input TX);
  modport slave  (input LOAD_EN, input TRANSMIT_EN, input DATA_IN, output DONE, output TX);
endinterface

// File: rtl/uart_tx_datapath.sv
// UART transmit data path: builds a start/data/parity/stop frame on load and shifts it
// out LSB first, one bit per BAUD_DIV clocks, signalling DONE after the last stop bit.
module uart_tx_datapath #(
  parameter int BAUD_DIV   = 434,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input logic              clk,
  input logic              rst,
  uart_tx_datapath_if.slave tx_if
);
  localparam int FRAME_LEN = 1 + DATA_WIDTH + PARITY_EN + STOP_BITS;
  localparam int BIT_W     = $clog2(FRAME_LEN + 1);
  localparam int BAUD_W    = $clog2(BAUD_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_LEN - 1);

  logic [FRAME_LEN-1:0] shift_q, shift_d, frame_w;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;
  logic                 parity_w, run_w, tick_w;

  assign parity_w = (^tx_if.DATA_IN) ^ (PARITY_ODD != 0);

  // Unused upper positions stay 1, which supplies the stop bits.
  always_comb begin
    frame_w                 = '1;
    frame_w[0]              = 1'b0;
    frame_w[DATA_WIDTH:1]   = tx_if.DATA_IN;
    if (PARITY_EN != 0) begin
      frame_w[DATA_WIDTH+1] = parity_w;
    end
  end

  // active_q keeps an unloaded or finished frame from counting, so DONE needs a fresh load.
  assign run_w  = tx_if.TRANSMIT_EN & active_q;
  assign tick_w = run_w & (baud_q == BAUD_LAST);

  always_comb begin
    shift_d  = shift_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    active_d = active_q;
    done_d   = 1'b0;
    if (tx_if.LOAD_EN) begin
      shift_d  = frame_w;
      baud_d   = '0;
      bit_d    = '0;
      active_d = 1'b1;
    end else if (tick_w) begin
      baud_d  = '0;
      shift_d = {1'b1, shift_q[FRAME_LEN-1:1]};
      bit_d   = bit_q + BIT_W'(1);
      if (bit_q == BIT_LAST) begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end
    end else if (run_w) begin
      baud_d = baud_q + BAUD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q  <= '1;
      baud_q   <= '0;
      bit_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign tx_if.TX   = tx_if.TRANSMIT_EN ? shift_q[0] : 1'b1;
  assign tx_if.DONE = done_q;
endmodule

// File: tb/tb_uart_tx_datapath.sv
// Four data-path configurations share one stimulus stream; each is compared every cycle
// against a frame-level model of what the serial line and DONE should show.
module tb_uart_tx_datapath;
  localparam int BAUD = 4;
  localparam logic [3:0] PE_V  = 4'b0110;
  localparam logic [3:0] PO_V  = 4'b0100;
  localparam logic [3:0] SB2_V = 4'b1000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_en = 1'b0;
  logic       transmit_en = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [3:0] tx_w, done_w;

  int         n_cmp = 0;
  int         n_fail = 0;
  int         k = 0;
  int         fl[4];
  logic [15:0] m_bits[4];
  int         m_n[4];
  logic [3:0] m_act, m_done;
  int         dcnt[4], dcyc[4], lowcnt[4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx_datapath_if #(.DATA_WIDTH(8)) bus ();
    assign bus.LOAD_EN     = load_en;
    assign bus.TRANSMIT_EN = transmit_en;
    assign bus.DATA_IN     = data_in;
    assign tx_w[g]         = bus.TX;
    assign done_w[g]       = bus.DONE;
    uart_tx_datapath #(
      .BAUD_DIV  (BAUD),
      .DATA_WIDTH(8),
      .PARITY_EN (int'(PE_V[g])),
      .PARITY_ODD(int'(PO_V[g])),
      .STOP_BITS (SB2_V[g] ? 2 : 1)
    ) dut (
      .clk  (clk),
      .rst  (rst),
      .tx_if(bus)
    );
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame as a list of line levels in transmit order.
  function automatic logic [15:0] build_frame(input int c, input logic [7:0] d);
    logic [15:0] f;
    int          pos;
    f = '1;
    f[0] = 1'b0;
    pos = 1;
    for (int i = 0; i < 8; i++) begin
      f[pos] = d[i];
      pos++;
    end
    if (PE_V[c]) f[pos] = (^d) ^ PO_V[c];
    return f;
  endfunction

  task automatic model_edge();
    for (int c = 0; c < 4; c++) begin
      m_done[c] = 1'b0;
      if (!rst) begin
        m_act[c] = 1'b0;
        m_n[c]   = 0;
      end else if (load_en) begin
        m_bits[c] = build_frame(c, data_in);
        m_n[c]    = 0;
        m_act[c]  = 1'b1;
      end else if (transmit_en && m_act[c]) begin
        m_n[c]++;
        if (m_n[c] == fl[c] * BAUD) begin
          m_act[c]  = 1'b0;
          m_done[c] = 1'b1;
        end
      end
    end
    if (load_en) k = 0;
  endtask

  task automatic check_outputs();
    logic exp_tx;
    k++;
    for (int c = 0; c < 4; c++) begin
      exp_tx = (transmit_en && m_act[c]) ? m_bits[c][m_n[c] / BAUD] : 1'b1;
      chk($sformatf("tx_c%0d_k%0d", c, k), 32'(tx_w[c]), 32'(exp_tx));
      chk($sformatf("done_c%0d_k%0d", c, k), 32'(done_w[c]), 32'(m_done[c]));
      if (done_w[c]) begin
        dcnt[c]++;
        dcyc[c] = k;
      end
      if (!tx_w[c]) lowcnt[c]++;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic clear_stats();
    for (int c = 0; c < 4; c++) begin
      dcnt[c]   = 0;
      dcyc[c]   = -1;
      lowcnt[c] = 0;
    end
  endtask

  task automatic load(input logic [7:0] d);
    load_en     = 1'b1;
    data_in     = d;
    transmit_en = 1'b1;
    cycle();
    load_en = 1'b0;
    data_in = $urandom;
  endtask

  task automatic run_frame(input logic [7:0] d, input int ncyc);
    clear_stats();
    load(d);
    for (int i = 1; i < ncyc; i++) begin
      cycle();
      if (d == 8'h07 && k == 38) begin
        chk("parity_even_0x07", 32'(tx_w[1]), 32'd1);
        chk("parity_odd_0x07", 32'(tx_w[2]), 32'd0);
      end
    end
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("done_count_c%0d_%02h", c, d), 32'(dcnt[c]), 32'd1);
      chk($sformatf("done_latency_c%0d_%02h", c, d), 32'(dcyc[c]), 32'(fl[c] * BAUD + 1));
    end
  endtask

  initial begin
    for (int c = 0; c < 4; c++) begin
      fl[c]     = 1 + 8 + int'(PE_V[c]) + (SB2_V[c] ? 2 : 1);
      m_bits[c] = '1;
      m_n[c]    = 0;
    end
    m_act  = '0;
    m_done = '0;
    clear_stats();

    cycle();
    cycle();
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("reset_tx_c%0d", c), 32'(tx_w[c]), 32'd1);
      chk($sformatf("reset_done_c%0d", c), 32'(done_w[c]), 32'd0);
    end
    rst = 1'b1;
    cycle();

    run_frame(8'h55, 50);
    run_frame(8'hA5, 50);
    run_frame(8'h07, 50);
    run_frame(8'hFF, 50);
    chk("stop2_low_cycles_0xFF", 32'(lowcnt[3]), 32'd4);

    // Asynchronous reset during data bit 3.
    clear_stats();
    load(8'h55);
    for (int i = 1; i < 18; i++) cycle();
    rst = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("rst_mid_tx_c%0d", c), 32'(tx_w[c]), 32'd1);
      chk($sformatf("rst_mid_done_c%0d", c), 32'(done_w[c]), 32'd0);
    end
    cycle();
    cycle();
    rst = 1'b1;
    transmit_en = 1'b1;
    clear_stats();
    for (int i = 0; i < 60; i++) cycle();
    for (int c = 0; c < 4; c++)
      chk($sformatf("no_done_after_rst_c%0d", c), 32'(dcnt[c]), 32'd0);
    run_frame(8'h3C, 50);

    // Reload during bit 5 aborts the first frame.
    clear_stats();
    load(8'h55);
    for (int i = 1; i < 22; i++) cycle();
    run_frame(8'h0F, 50);

    // Random frames with TRANSMIT_EN gaps and occasional aborting reloads.
    for (int f = 0; f < 25; f++) begin
      int cnt;
      clear_stats();
      load(8'($urandom));
      cnt = 0;
      while (m_act != 0 && cnt < 400) begin
        transmit_en = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 99) == 0) begin
          load_en = 1'b1;
          data_in = 8'($urandom);
        end
        cycle();
        load_en = 1'b0;
        cnt++;
      end
      chk($sformatf("rand_frame%0d_finished", f), 32'(m_act == 0), 32'd1);
      transmit_en = 1'b1;
      for (int i = 0; i < 3; i++) cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_datapath.md
Name: uart_tx_datapath

Overview:
UART transmit data path, driven by the UART TX control state machine.
- Captures a parallel byte when the controller pulses LOAD_EN.
- Serialises start, data (LSB first), optional parity and stop bits at a programmable baud rate while TRANSMIT_EN is high.
- Returns a one-cycle DONE pulse to the controller when the last stop bit completes; drives the serial line TX.

Parameters:
BAUD_DIV, 434, clk cycles per bit (50 MHz / 115200); legal range >= 2
DATA_WIDTH, 8, data bits per frame
PARITY_EN, 0, 1 = append a parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
LOAD_EN  input  1  from controller; 1-cycle pulse, latch DATA_IN and build frame
TRANSMIT_EN  input  1  from controller; level, high while frame is shifted
DATA_IN  input  DATA_WIDTH  parallel byte to send; sampled only when LOAD_EN=1
DONE  output  1  to controller; 1-cycle pulse after final stop bit
TX  output  1  serial line, idle high

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk.
- Reset values: shift register all 1s, baud counter 0, bit counter 0, DONE 0, TX 1.
- Frame length FRAME_LEN = 1 + DATA_WIDTH + PARITY_EN + STOP_BITS; bit counter width = clog2(FRAME_LEN+1).
- Load:
  - LOAD_EN=1 at a rising edge loads the shift register with {STOP_BITS x 1, parity (if enabled), DATA_IN, 1'b0}; the LSB is the start bit.
  - The same edge clears the baud counter and bit counter.
  - DATA_IN is ignored at all other times.
- Parity bit = XOR of DATA_IN bits when PARITY_ODD=0; inverted XOR when PARITY_ODD=1.
- TX = shift_reg[0] while TRANSMIT_EN=1, otherwise 1. TX is combinational from registers and TRANSMIT_EN.
- Baud counter: counts 0..BAUD_DIV-1 while TRANSMIT_EN=1 and no frame-complete condition holds.
- At terminal count (BAUD_DIV-1):
  - counter wraps to 0;
  - shift register shifts right, filling with 1;
  - bit counter increments.
- Each frame bit is therefore present on TX for exactly BAUD_DIV cycles. The start bit appears in the first TRANSMIT_EN cycle after load.
- DONE:
  - registered; asserted for exactly one cycle, in the cycle after the terminal tick of bit FRAME_LEN-1;
  - TX = 1 during that cycle (shift register all 1s);
  - after DONE, counters hold until the next LOAD_EN; no further DONE without a new load.
- Priority: LOAD_EN over TRANSMIT_EN. LOAD_EN during a frame aborts it and restarts a fresh frame; no DONE is issued for the aborted frame.
- TRANSMIT_EN low mid-frame: counters and shift register hold, TX = 1. Shifting resumes where it stopped when TRANSMIT_EN returns.
- Reset mid-frame: immediate (asynchronous) return to reset values; TX = 1 and no DONE.
- Latency from LOAD_EN edge to DONE, with TRANSMIT_EN continuous from the next cycle: FRAME_LEN*BAUD_DIV + 1 cycles.

Test Plan:
1. BAUD_DIV=4, no parity, 1 stop; LOAD_EN with DATA_IN=0x55 then TRANSMIT_EN held.
   -> TX = 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles.
   -> DONE pulses once, 41 cycles after the LOAD_EN edge; TX = 1 afterwards.
2. DATA_IN=0xA5, same config.
   -> data bits on TX LSB first: 1,0,1,0,0,1,0,1, between start 0 and stop 1.
3. PARITY_EN=1, DATA_IN=0x07.
   -> PARITY_ODD=0: parity bit = 1; PARITY_ODD=1: parity bit = 0.
   -> DONE at 45 cycles (FRAME_LEN=11).
4. STOP_BITS=2, DATA_IN=0xFF.
   -> TX low only for the 4-cycle start bit, then high for 10 bits; DONE at 45 cycles.
5. rst asserted low during data bit 3.
   -> TX = 1 and DONE = 0 immediately; no DONE after release.
   -> A new LOAD_EN sends a complete, correct frame.
6. LOAD_EN with 0x0F during bit 5 of a 0x55 frame.
   -> new frame restarts with its start bit; exactly one DONE, for 0x0F, 41 cycles after the second LOAD_EN.
